// File: rtl/om_arb_pkg.sv
// Shared encodings for the order-request arbiter: order manager states, arbiter FSM states
// and completion status codes.
package om_arb_pkg;

  typedef enum logic [3:0] {
    OmIdle         = 4'd0,
    OmRiskCheck    = 4'd1,
    OmPrepareOrder = 4'd2,
    OmSendOrder    = 4'd3,
    OmAwaitingFill = 4'd4,
    OmFilled       = 4'd5,
    OmRejected     = 4'd6
  } om_state_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitDone = 2'd1,
    StDrain    = 2'd2
  } arb_state_e;

  localparam logic [1:0] DONE_FILLED   = 2'b01;
  localparam logic [1:0] DONE_REJECTED = 2'b10;
  localparam logic [1:0] DONE_TIMEOUT  = 2'b11;

  // Requester index width; never zero so single-bit indices stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/order_request_arbiter_if.sv
// Requester-side and order-manager-side signals of the arbiter, bundled with modports.
interface order_request_arbiter_if
  import om_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned QTY_W   = 32
) ();

  localparam int unsigned IdxW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*QTY_W-1:0] req_qty;
  logic [NUM_REQ*8-1:0]     req_side;
  logic [NUM_REQ-1:0]       req_ready;

  logic [3:0]               om_state;
  logic                     om_trade_signal;
  logic [QTY_W-1:0]         om_trade_qty;
  logic [7:0]               om_trade_side;

  logic                     done_valid;
  logic [IdxW-1:0]          done_id;
  logic [1:0]               done_status;

  modport master (
    output req_valid, req_qty, req_side, om_state,
    input  req_ready, om_trade_signal, om_trade_qty, om_trade_side,
    input  done_valid, done_id, done_status
  );

  modport slave (
    input  req_valid, req_qty, req_side, om_state,
    output req_ready, om_trade_signal, om_trade_qty, om_trade_side,
    output done_valid, done_id, done_status
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping around.
module rr_picker
  import om_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [idx_w(NUM_REQ)-1:0]   idx,
  output logic                        any_valid
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(ptr) + i) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!any_valid && req[cand_idx]) begin
        any_valid       = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/order_request_arbiter.sv
// Round-robin arbiter sharing one order-manager transaction path among NUM_REQ strategies,
// tracking each issued trade to fill, reject or watchdog timeout.
module order_request_arbiter
  import om_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned QTY_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  order_request_arbiter_if.slave bus,
  output logic                  busy,
  output logic [31:0]           grant_count,
  output logic [31:0]           timeout_count
);

  localparam int unsigned IdxW   = idx_w(NUM_REQ);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

  arb_state_e       state_q;
  logic [IdxW-1:0]  ptr_q;
  logic [IdxW-1:0]  owner_q;
  logic [TimerW-1:0] timer_q;
  logic             trade_signal_q;
  logic [QTY_W-1:0] trade_qty_q;
  logic [7:0]       trade_side_q;
  logic             done_valid_q;
  logic [IdxW-1:0]  done_id_q;
  logic [1:0]       done_status_q;
  logic [31:0]      grant_count_q;
  logic [31:0]      timeout_count_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic               grant_ok;
  logic [QTY_W-1:0]   qty_sel;
  logic [7:0]         side_sel;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // The winner is always valid, so an asserted ready is itself the transfer.
  assign grant_ok = (state_q == StIdle) && enable && (bus.om_state == OmIdle) && pick_any;

  always_comb begin
    qty_sel  = '0;
    side_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        qty_sel  = bus.req_qty[i*QTY_W +: QTY_W];
        side_sel = bus.req_side[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      owner_q         <= '0;
      timer_q         <= '0;
      trade_signal_q  <= 1'b0;
      trade_qty_q     <= '0;
      trade_side_q    <= '0;
      done_valid_q    <= 1'b0;
      done_id_q       <= '0;
      done_status_q   <= '0;
      grant_count_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      trade_signal_q <= 1'b0;
      done_valid_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_ok) begin
            owner_q        <= pick_idx;
            trade_qty_q    <= qty_sel;
            trade_side_q   <= side_sel;
            trade_signal_q <= 1'b1;
            grant_count_q  <= grant_count_q + 32'd1;
            ptr_q          <= (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + IdxW'(1);
            timer_q        <= '0;
            state_q        <= StWaitDone;
          end
        end
        StWaitDone: begin
          timer_q <= timer_q + TimerW'(1);
          if (bus.om_state == OmFilled) begin
            done_valid_q  <= 1'b1;
            done_id_q     <= owner_q;
            done_status_q <= DONE_FILLED;
            state_q       <= StDrain;
          end else if (bus.om_state == OmRejected) begin
            done_valid_q  <= 1'b1;
            done_id_q     <= owner_q;
            done_status_q <= DONE_REJECTED;
            state_q       <= StDrain;
          end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
            done_valid_q    <= 1'b1;
            done_id_q       <= owner_q;
            done_status_q   <= DONE_TIMEOUT;
            timeout_count_q <= timeout_count_q + 32'd1;
            state_q         <= StIdle;
          end
        end
        StDrain: begin
          if (bus.om_state == OmIdle) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready       = grant_ok ? pick_grant : '0;
  assign bus.om_trade_signal = trade_signal_q;
  assign bus.om_trade_qty    = trade_qty_q;
  assign bus.om_trade_side   = trade_side_q;
  assign bus.done_valid      = done_valid_q;
  assign bus.done_id         = done_id_q;
  assign bus.done_status     = done_status_q;
  assign busy                = (state_q != StIdle);
  assign grant_count         = grant_count_q;
  assign timeout_count       = timeout_count_q;

endmodule

// File: tb/tb_order_request_arbiter.sv
// Directed bench for order_request_arbiter: fill, reject, timeout, round robin, enable, reset.
module tb_order_request_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned QW = 32;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        busy;
  logic [31:0] grant_count;
  logic [31:0] timeout_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [QW-1:0] exp_qty [N];
  logic [7:0]    exp_side[N];

  always #5 clk = ~clk;

  order_request_arbiter_if #(.NUM_REQ(N), .QTY_W(QW)) bus ();

  order_request_arbiter #(
    .NUM_REQ        (N),
    .QTY_W          (QW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .bus           (bus),
    .busy          (busy),
    .grant_count   (grant_count),
    .timeout_count (timeout_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_qty[i*QW +: QW] = exp_qty[i];
      bus.req_side[i*8 +: 8]  = exp_side[i];
    end
  endtask

  // Entered in cycle T with requests settled; returns at the negedge of the first IDLE cycle.
  task automatic txn(input int id, input logic [3:0] fin, input int lat, input logic [1:0] st,
                     input int hold, input bit drop_en, input logic [N-1:0] valid_after);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    chk("req_ready_winner", 64'(bus.req_ready), 64'(oh));
    cyc();
    bus.req_valid = valid_after;
    if (drop_en) enable = 1'b0;
    bus.om_state = 4'd1;
    #1;
    chk("issue_pulse", 64'(bus.om_trade_signal), 64'd1);
    chk("issue_qty", 64'(bus.om_trade_qty), 64'(exp_qty[id]));
    chk("issue_side", 64'(bus.om_trade_side), 64'(exp_side[id]));
    chk("busy_in_flight", 64'(busy), 64'd1);
    chk("ready_in_flight", 64'(bus.req_ready), 64'd0);
    for (int c = 2; c < lat; c++) begin
      cyc();
      bus.om_state = (c < 4) ? 4'(c) : 4'd4;
      #1;
      if (c == 2) chk("issue_pulse_single", 64'(bus.om_trade_signal), 64'd0);
    end
    cyc();
    bus.om_state = fin;
    #1;
    chk("no_early_done", 64'(bus.done_valid), 64'd0);
    cyc();
    #1;
    chk("done_valid", 64'(bus.done_valid), 64'd1);
    chk("done_id", 64'(bus.done_id), 64'(id));
    chk("done_status", 64'(bus.done_status), 64'(st));
    chk("qty_held", 64'(bus.om_trade_qty), 64'(exp_qty[id]));
    chk("side_held", 64'(bus.om_trade_side), 64'(exp_side[id]));
    for (int h = 0; h < hold; h++) begin
      cyc();
      #1;
      chk("done_single_pulse", 64'(bus.done_valid), 64'd0);
      chk("ready_in_drain", 64'(bus.req_ready), 64'd0);
    end
    bus.om_state = 4'd0;
    #1;
    chk("ready_on_drain_exit", 64'(bus.req_ready), 64'd0);
    cyc();
  endtask

  initial begin
    bit early;
    rstn          = 1'b0;
    enable        = 1'b0;
    bus.req_valid = '0;
    bus.req_qty   = '0;
    bus.req_side  = '0;
    bus.om_state  = 4'd0;
    for (int i = 0; i < N; i++) begin
      exp_qty[i]  = '0;
      exp_side[i] = '0;
    end
    #2;
    chk("rst_trade_signal", 64'(bus.om_trade_signal), 64'd0);
    chk("rst_trade_qty", 64'(bus.om_trade_qty), 64'd0);
    chk("rst_trade_side", 64'(bus.om_trade_side), 64'd0);
    chk("rst_done", {61'd0, bus.done_valid, bus.done_status}, 64'd0);
    chk("rst_done_id", 64'(bus.done_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_counts", {grant_count, timeout_count}, 64'd0);
    repeat (2) cyc();
    rstn = 1'b1;

    // Single request, filled, valid dropped after transfer.
    cyc();
    enable = 1'b1;
    exp_qty[0] = 32'd100;
    exp_side[0] = 8'd1;
    pack();
    bus.req_valid = 4'b0001;
    #1;
    txn(0, 4'd5, 7, 2'b01, 0, 1'b0, 4'b0000);
    #1;
    chk("single_grant_count", 64'(grant_count), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);

    // Fresh pointer for the round-robin sequence.
    rstn = 1'b0;
    #1;
    chk("rst2_grant_count", 64'(grant_count), 64'd0);
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_qty[i]  = 32'h1000_0000 + 32'(i * 17);
      exp_side[i] = (i % 2 == 1) ? 8'h02 : 8'h01;
    end
    pack();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      txn(k % 4, 4'd6, 4, 2'b10, 0, 1'b0, 4'b1111);
    end
    bus.req_valid = 4'b0000;
    #1;
    chk("rr_grant_count", 64'(grant_count), 64'd5);

    // Reject with a slow return to idle: no grant while draining.
    bus.req_valid = 4'b0010;
    #1;
    txn(1, 4'd6, 4, 2'b10, 3, 1'b0, 4'b0010);
    #1;
    chk("ready_after_drain", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = 4'b0000;

    // Timeout: order manager stuck in AWAITING_FILL.
    bus.req_valid = 4'b0100;
    #1;
    chk("to_ready", 64'(bus.req_ready), 64'b0100);
    cyc();
    bus.om_state = 4'd4;
    #1;
    chk("to_issue", 64'(bus.om_trade_signal), 64'd1);
    early = 1'b0;
    for (int c = 2; c <= TO; c++) begin
      cyc();
      #1;
      if (bus.done_valid !== 1'b0 || bus.req_ready !== '0) early = 1'b1;
    end
    chk("to_quiet_until_timeout", 64'(early), 64'd0);
    cyc();
    #1;
    chk("to_done_valid", 64'(bus.done_valid), 64'd1);
    chk("to_done_status", 64'(bus.done_status), 64'b11);
    chk("to_done_id", 64'(bus.done_id), 64'd2);
    chk("to_count", 64'(timeout_count), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_blocked_by_om", 64'(bus.req_ready), 64'd0);
    bus.om_state = 4'd0;
    #1;
    chk("to_ready_om_idle", 64'(bus.req_ready), 64'b0100);

    // Enable low blocks grants.
    enable = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    chk("en_off_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    #1;
    chk("en_off_idle", 64'(busy), 64'd0);
    chk("en_off_grant_count", 64'(grant_count), 64'd7);

    // Enable dropped mid-transaction: the fill still completes, then nothing new.
    enable = 1'b1;
    #1;
    txn(0, 4'd5, 7, 2'b01, 0, 1'b1, 4'b0011);
    #1;
    chk("en_drop_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    #1;
    chk("en_drop_idle", 64'(busy), 64'd0);
    chk("en_drop_grant_count", 64'(grant_count), 64'd8);

    // Reset mid-transaction.
    enable = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    chk("mid_ready", 64'(bus.req_ready), 64'b1000);
    cyc();
    bus.om_state = 4'd2;
    #1;
    chk("mid_issue", 64'(bus.om_trade_signal), 64'd1);
    cyc();
    cyc();
    rstn = 1'b0;
    #1;
    chk("mid_rst_qty_side", {bus.om_trade_qty, 24'd0, bus.om_trade_side}, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", {61'd0, bus.done_valid, bus.done_status}, 64'd0);
    chk("mid_rst_counts", {grant_count, timeout_count}, 64'd0);
    bus.om_state  = 4'd0;
    bus.req_valid = 4'b1010;
    cyc();
    #1;
    chk("mid_no_done", 64'(bus.done_valid), 64'd0);
    rstn = 1'b1;
    #1;
    txn(1, 4'd5, 7, 2'b01, 0, 1'b0, 4'b0000);
    #1;
    chk("post_rst_grant_count", 64'(grant_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/order_request_arbiter.md
Name: order_request_arbiter

Overview:
- Shares the single order-manager transaction path between NUM_REQ strategy requesters using round-robin arbitration.
- Accepts one request at a time, issues a one-cycle trade_signal with stable qty/side, then tracks the order manager's state_out until FILLED or REJECTED.
- A watchdog timeout covers the case where no completion is seen.
- Reports a tagged completion to the requesters; sits between the strategy bank and the order manager.

Parameters:
NUM_REQ, 4, number of strategy requesters (2..16)
QTY_W, 32, width of the trade quantity
TIMEOUT_CYCLES, 64, cycles after issue before a timeout is declared (>=16)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
enable  input  1  when 0, no new grants are issued; any in-flight transaction completes
req_valid  input  NUM_REQ  per-requester request pending
req_qty  input  NUM_REQ*QTY_W  packed quantities, requester i at [i*QTY_W +: QTY_W]
req_side  input  NUM_REQ*8  packed sides, 1 = buy, other values = sell
req_ready  output  NUM_REQ  combinational one-hot accept; transfer when req_valid[i] and req_ready[i] are both high
om_state  input  4  order manager state_out
om_trade_signal  output  1  one-cycle issue pulse to the order manager
om_trade_qty  output  QTY_W  quantity to the order manager
om_trade_side  output  8  side to the order manager
done_valid  output  1  one-cycle completion pulse
done_id  output  $clog2(NUM_REQ)  requester owning the completion
done_status  output  2  01 = filled, 10 = rejected, 11 = timeout
busy  output  1  high whenever state is not IDLE
grant_count  output  32  accepted requests, wraps
timeout_count  output  32  timeouts, wraps

Behaviour:
- States:
  - IDLE: accepting requests.
  - WAIT_DONE: transaction in flight.
  - DRAIN: waiting for the order manager to return to idle.
- Reset values: state = IDLE, round-robin pointer = 0; all outputs 0, including om_trade_qty/side, done_id and both counters.
- Reset mid-transaction aborts the transaction with no done pulse.
- Grant condition in IDLE: enable=1 and om_state==0 and |req_valid.
  - Winner is the first asserted req_valid searching upward from the pointer, with wrap-around.
  - req_ready is asserted only for the winner.
  - In all other states, or when the grant condition fails, req_ready = 0.
- On the transfer edge:
  - latch winner id, qty and side into om_trade_qty/side;
  - set om_trade_signal <= 1 and grant_count += 1;
  - pointer <= (winner+1) mod NUM_REQ;
  - clear the timer and move to WAIT_DONE.
- om_trade_signal is high for exactly the first cycle of WAIT_DONE.
- om_trade_qty and om_trade_side stay stable from issue until done_valid. This hold is mandatory because the order manager samples side live during PREPARE_ORDER.
- In WAIT_DONE the timer increments every cycle, and om_state is checked in this priority order:
  - om_state == 5 (FILLED): done status 01, go to DRAIN.
  - om_state == 6 (REJECTED): done status 10, go to DRAIN.
  - timer == TIMEOUT_CYCLES-1: done status 11, timeout_count += 1, go to IDLE.
- done_valid, done_id and done_status are registered and asserted in the cycle after detection.
- DRAIN: stay until om_state == 0, then go to IDLE. No grant is allowed in the same cycle as the DRAIN exit.
- Nominal latency, with issue pulse in cycle T+1:
  - fill: om_state = 5 in T+7, done_valid in T+8.
  - reject: om_state = 6 in T+4, done_valid in T+5.
- om_state values 1..4 and 7..15, or om_state X after reset, never produce completion; they only block grants. Timeout still applies.
- enable falling during WAIT_DONE or DRAIN does not affect the current transaction.
- req_valid dropping after transfer is ignored.
- A requester must not change its qty/side while valid and not ready.
- Counters wrap from 2^32-1 to 0 silently.

Decomposition:
- Package om_arb_pkg holds:
  - order manager state encodings (IDLE=0, RISK_CHECK=1, PREPARE_ORDER=2, SEND_ORDER=3, AWAITING_FILL=4, FILLED=5, REJECTED=6);
  - arbiter state encoding;
  - done_status codes (DONE_FILLED=2'b01, DONE_REJECTED=2'b10, DONE_TIMEOUT=2'b11).
- One sub-module, rr_picker: combinational round-robin search taking req vector and pointer, producing one-hot grant, index and any-valid. Parameterised by NUM_REQ.

Test Plan:
- Single request: req_valid=0001, qty=100, side=1, om model fills → req_ready[0] for 1 cycle; om_trade_signal 1 cycle; qty=100 and side=1 held; done_valid in T+8 with id=0, status=01; grant_count=1.
- Round robin: req_valid=1111 held for 5 transactions → grant order 0,1,2,3,0; pointer wraps.
- Reject: om model returns REJECTED → done_valid in T+5 with status=10; next grant allowed only after om_state returns to 0.
- Timeout: om model stuck in state 4, TIMEOUT_CYCLES=64 → done status=11 exactly 64 cycles after issue (registered); timeout_count=1; no grant while om_state!=0.
- Enable: enable=0 with req_valid=0011 → no req_ready. Dropping enable mid-WAIT_DONE → current done still reported, then no new grant.
- Reset mid-transaction: rstn low in WAIT_DONE → all outputs 0 asynchronously, no done pulse; after release, first grant goes to the lowest-index valid requester.
